// File: rtl/pixel_pkg.sv
// Shared framebuffer geometry and pixel addressing helpers for the shadow
// reader and the collision / AI blocks that will query it.
package pixel_pkg;

  localparam int unsigned H_RES    = 160;
  localparam int unsigned V_RES    = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned PIXELS   = H_RES * V_RES;

  localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000;
  localparam logic [ADDR_W-1:0]   LAST_ADDR    = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0]   PRE_LAST     = ADDR_W'(PIXELS - 2);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // y*160 + x as two shifts; y is widened first so nothing is lost in the sum
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] px,
                                                 input logic [Y_W-1:0] py);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(py);
    return (yw << 7) + (yw << 5) + ADDR_W'(px);
  endfunction

  function automatic logic in_range(input logic [X_W-1:0] px,
                                    input logic [Y_W-1:0] py);
    return (32'(px) < H_RES) && (32'(py) < V_RES);
  endfunction

endpackage

// File: rtl/shadow_ram.sv
// Simple dual-port shadow framebuffer: one write port, one registered read
// port, read-before-write on an address collision. No reset on the array.
module shadow_ram
  import pixel_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem [PIXELS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pixel_shadow_reader.sv
// Snoops the pixel plot stream into a shadow framebuffer and answers
// 1-cycle-latency colour queries; a clear sweep keeps it matching the screen.
module pixel_shadow_reader
  import pixel_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear_req,
  input  logic                rd_req,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic                rd_valid,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic                busy,
  output logic                clear_done,
  output logic [7:0]          drop_count
);

  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  // Assert asynchronously, release two clocks later in the clk domain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_addr_reg;
  logic                busy_reg;
  logic                clear_done_reg;
  logic [7:0]          drop_count_reg;
  logic                rd_valid_reg;
  logic                rd_oob_reg;

  logic                clearing;
  logic                plot_ok;
  logic                rd_ok;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [COLOUR_W-1:0] wr_data;
  logic [COLOUR_W-1:0] ram_rd_data;

  assign clearing = (state_reg == ST_CLEAR);
  assign plot_ok  = plot && in_range(x, y);
  assign rd_ok    = in_range(rd_x, rd_y);

  // The sweep owns the write port; snooped plots only land in IDLE
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr_reg;
    wr_data = CLEAR_COLOUR;
    if (clearing) begin
      wr_en = 1'b1;
    end else if (plot_ok) begin
      wr_en   = 1'b1;
      wr_addr = pix_addr(x, y);
      wr_data = colour;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg      <= ST_CLEAR;
      clr_addr_reg   <= '0;
      busy_reg       <= 1'b1;
      clear_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_addr_reg   <= clr_addr_reg + ADDR_W'(1);
          // Raised one edge early so the pulse coincides with the last write
          clear_done_reg <= (clr_addr_reg == PRE_LAST);
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg      <= ST_IDLE;
            clr_addr_reg   <= '0;
            busy_reg       <= 1'b0;
            clear_done_reg <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      drop_count_reg <= '0;
    end else if (clearing && plot_ok && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  // The out-of-range flag starts set so rd_colour reads as CLEAR_COLOUR
  // before the RAM output register has ever been loaded.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rd_valid_reg <= 1'b0;
      rd_oob_reg   <= 1'b1;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_oob_reg <= !rd_ok;
      end
    end
  end

  shadow_ram u_shadow_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_req && rd_ok),
    .rd_addr (pix_addr(rd_x, rd_y)),
    .rd_data (ram_rd_data)
  );

  assign rd_valid   = rd_valid_reg;
  assign rd_colour  = rd_oob_reg ? CLEAR_COLOUR : ram_rd_data;
  assign busy       = busy_reg;
  assign clear_done = clear_done_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_pixel_shadow_reader.sv
// Directed self-checking bench for pixel_shadow_reader.
module tb_pixel_shadow_reader;

  logic       clk;
  logic       resetn;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       clear_req;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic       busy;
  logic       clear_done;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_shadow_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .clear_req  (clear_req),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .busy       (busy),
    .clear_done (clear_done),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks are entered and left at a negedge; inputs change there and
  // outputs are sampled there, half a period away from the active edge.
  task automatic do_plot(input int px, input int py, input int pc);
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(pc);
    @(negedge clk);
    plot = 1'b0;
    $display("plot (%0d,%0d) colour=%0d", px, py, pc);
  endtask

  task automatic do_read(input int rx, input int ry, output logic v, output logic [2:0] c);
    rd_req = 1'b1; rd_x = 8'(rx); rd_y = 7'(ry);
    @(negedge clk);
    v = rd_valid; c = rd_colour;
    rd_req = 1'b0;
    $display("read (%0d,%0d) -> valid=%0b colour=%0d", rx, ry, v, c);
  endtask

  // Counts busy cycles of one sweep; skip covers the reset release latency
  task automatic measure_sweep(input int skip, output int busy_cycles, output int pulses);
    busy_cycles = 0; pulses = 0;
    repeat (skip) @(posedge clk);
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (clear_done) pulses++;
      if (!busy) break;
      busy_cycles++;
    end
    $display("sweep: busy for %0d cycles, %0d clear_done pulses", busy_cycles, pulses);
  endtask

  task automatic test_reset;
    int cyc, pulses;
    logic v;
    logic [2:0] c;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b want 1", busy); end
    n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset_clear_done: got %0b want 0", clear_done); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    n_checks++; if (rd_colour !== 3'd0) begin n_fail++; $display("FAIL reset_rd_colour: got %0d want 0", rd_colour); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    resetn = 1'b1;
    measure_sweep(2, cyc, pulses);
    n_checks++; if (cyc != 19200) begin n_fail++; $display("FAIL initial_sweep_len: got %0d want 19200", cyc); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL initial_clear_done: got %0d pulses want 1", pulses); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL initial_busy_low: got %0b want 0", busy); end
    do_read(159, 119, v, c);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL corner_read_valid: got %0b want 1", v); end
    n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL corner_read_colour: got %0d want 0", c); end
  endtask

  task automatic test_plot_read;
    logic v;
    logic [2:0] c;
    do_plot(10, 20, 5);
    do_read(10, 20, v, c);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL plot_read_valid: got %0b want 1", v); end
    n_checks++; if (c !== 3'b101) begin n_fail++; $display("FAIL plot_read_colour: got %0d want 5", c); end
    do_read(11, 20, v, c);
    n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL neighbour_colour: got %0d want 0", c); end
    do_read(10, 20, v, c);
    @(negedge clk);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rd_valid: got %0b want 0", rd_valid); end
    n_checks++; if (rd_colour !== 3'b101) begin n_fail++; $display("FAIL hold_rd_colour: got %0d want 5", rd_colour); end
  endtask

  task automatic test_collision;
    plot = 1'b1; x = 8'd5; y = 7'd5; colour = 3'b111;
    rd_req = 1'b1; rd_x = 8'd5; rd_y = 7'd5;
    @(negedge clk);
    plot = 1'b0;
    $display("collision read (5,5) -> valid=%0b colour=%0d", rd_valid, rd_colour);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL collision_valid: got %0b want 1", rd_valid); end
    n_checks++; if (rd_colour !== 3'd0) begin n_fail++; $display("FAIL collision_old_data: got %0d want 0", rd_colour); end
    @(negedge clk);
    rd_req = 1'b0;
    $display("reread (5,5) -> colour=%0d", rd_colour);
    n_checks++; if (rd_colour !== 3'b111) begin n_fail++; $display("FAIL collision_new_data: got %0d want 7", rd_colour); end
  endtask

  task automatic test_back_to_back;
    int qx [4] = '{0, 159, 0, 159};
    int qy [4] = '{0, 0, 119, 119};
    logic [2:0] exp_c [4] = '{3'd1, 3'd2, 3'd4, 3'd6};
    for (int i = 0; i < 4; i++) do_plot(qx[i], qy[i], int'(exp_c[i]));
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        rd_req = 1'b1; rd_x = 8'(qx[i]); rd_y = 7'(qy[i]);
      end else begin
        rd_req = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        $display("pipelined read (%0d,%0d) -> valid=%0b colour=%0d", qx[i], qy[i], rd_valid, rd_colour);
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %0b want 1", i, rd_valid); end
        n_checks++; if (rd_colour !== exp_c[i]) begin n_fail++; $display("FAIL b2b_colour_%0d: got %0d want %0d", i, rd_colour, exp_c[i]); end
      end
    end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid: got %0b want 0", rd_valid); end
  endtask

  task automatic test_out_of_range;
    logic v;
    logic [2:0] c;
    do_plot(40, 51, 3);
    do_plot(160, 20, 6);
    do_plot(10, 120, 6);
    do_read(0, 21, v, c);
    n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL oob_x_alias: got %0d want 0", c); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL oob_drop_count: got %0d want 0", drop_count); end
    do_read(40, 51, v, c);
    n_checks++; if (c !== 3'd3) begin n_fail++; $display("FAIL alias_target: got %0d want 3", c); end
    do_read(200, 50, v, c);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL oob_read_valid: got %0b want 1", v); end
    n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL oob_read_colour: got %0d want 0", c); end
  endtask

  task automatic test_clear_drop;
    int cyc, pulses;
    logic v;
    logic [2:0] c;
    int rx [5] = '{10, 0, 159, 40, 50};
    int ry [5] = '{20, 0, 0, 51, 0};
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    cyc = 0; pulses = 0;
    // Plots land on row 0 after the sweep has passed it; a re-request mid-sweep must be ignored
    for (int i = 0; i < 25000; i++) begin
      if (clear_done) pulses++;
      if (!busy) break;
      cyc++;
      plot = (cyc > 200) && (cyc <= 500);
      x = 8'(cyc % 160); y = 7'd0; colour = 3'b111;
      clear_req = (cyc == 600);
      @(negedge clk);
    end
    plot = 1'b0; clear_req = 1'b0;
    $display("clear sweep: busy for %0d cycles, %0d pulses, drop_count=%0d", cyc, pulses, drop_count);
    n_checks++; if (cyc != 19200) begin n_fail++; $display("FAIL clear_sweep_len: got %0d want 19200", cyc); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL clear_done_pulses: got %0d want 1", pulses); end
    n_checks++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturated: got %0d want 255", drop_count); end
    for (int i = 0; i < 5; i++) begin
      do_read(rx[i], ry[i], v, c);
      n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL cleared_%0d_%0d: got %0d want 0", rx[i], ry[i], c); end
    end
  endtask

  task automatic test_reset_midclear;
    int cyc, pulses;
    logic v;
    logic [2:0] c;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (5000) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclear_busy: got %0b want 1", busy); end
    n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL midclear_done: got %0b want 0", clear_done); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL midclear_drop_reset: got %0d want 0", drop_count); end
    resetn = 1'b1;
    measure_sweep(2, cyc, pulses);
    n_checks++; if (cyc != 19200) begin n_fail++; $display("FAIL restart_sweep_len: got %0d want 19200", cyc); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL restart_clear_done: got %0d pulses want 1", pulses); end
    do_read(0, 119, v, c);
    n_checks++; if (c !== 3'd0) begin n_fail++; $display("FAIL restart_read: got %0d want 0", c); end
  endtask

  initial begin
    resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
    test_reset;
    test_plot_read;
    test_collision;
    test_back_to_back;
    test_out_of_range;
    test_clear_drop;
    test_reset_midclear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
